// File: rtl/fetch_controller.sv
// fetch_controller: sequential instruction fetch from a combinational
// instruction memory into a 2-entry {pc, instr} output buffer, with
// redirect, halt and sticky out-of-range fault handling.
//
// Output handshake: out_valid is high whenever the buffer holds at least one
// entry, and out_pc/out_instr then show the oldest entry. They stay unchanged
// until the consumer raises out_ready. An entry transfers on every rising edge
// where out_valid and out_ready are both 1. out_valid does not depend on
// out_ready.
module fetch_controller #(
  parameter logic [31:0] RESET_PC   = 32'h00000000,
  parameter int          IMEM_WORDS = 256
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_instr,
  input  logic        halt,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc,
  output logic        fault,
  output logic [1:0]  dbg_state
);

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    HALTED = 2'd1,
    FAULT  = 2'd2
  } state_t;

  // One past the last valid byte address. It is 33 bits wide so that a
  // memory covering the full 4 GiB space still compares correctly.
  localparam logic [32:0] ADDR_LIMIT = 33'(4 * IMEM_WORDS);

  state_t      state;
  state_t      state_nxt;
  logic [31:0] pc;
  logic [1:0]  count;
  logic [31:0] e0_pc;
  logic [31:0] e0_instr;
  logic [31:0] e1_pc;
  logic [31:0] e1_instr;

  logic        pop;
  logic        want_fetch;
  logic        in_range;
  logic        fetch;
  logic        fault_hit;

  // Fetch/pop qualification. A redirect suppresses both in its cycle.
  always_comb begin
    imem_addr  = pc & 32'hFFFF_FFFC;
    pop        = out_valid && out_ready && !redirect_valid;
    want_fetch = (state == RUN) && !redirect_valid && ((count != 2'd2) || pop);
    in_range   = ({1'b0, imem_addr} < ADDR_LIMIT);
    fetch      = want_fetch && in_range;
    fault_hit  = want_fetch && !in_range;
  end

  // Next-state logic. A redirect leaves the state alone, so halt is ignored
  // in that cycle and HALTED is not left.
  always_comb begin
    state_nxt = state;
    case (state)
      RUN: begin
        if (!redirect_valid) begin
          if (fault_hit) state_nxt = FAULT;
          else if (halt) state_nxt = HALTED;
        end
      end
      HALTED: begin
        if (!redirect_valid && !halt) state_nxt = RUN;
      end
      FAULT:   state_nxt = FAULT;
      default: state_nxt = RUN;
    endcase
  end

  // State register. FAULT is sticky until reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= RUN;
    else       state <= state_nxt;
  end

  // pc, buffer and occupancy. Entry 0 is always the oldest. A pop shifts
  // entry 1 down, and a push fills the first free slot after any pop.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc       <= RESET_PC;
      count    <= 2'd0;
      e0_pc    <= 32'h0;
      e0_instr <= 32'h0;
      e1_pc    <= 32'h0;
      e1_instr <= 32'h0;
    end else if (redirect_valid) begin
      count <= 2'd0;
      pc    <= redirect_target & 32'hFFFF_FFFC;
    end else begin
      if (fetch) pc <= pc + 32'd4;
      case ({fetch, pop})
        2'b10: begin
          if (count == 2'd0) begin
            e0_pc    <= imem_addr;
            e0_instr <= imem_instr;
          end else begin
            e1_pc    <= imem_addr;
            e1_instr <= imem_instr;
          end
          count <= count + 2'd1;
        end
        2'b01: begin
          e0_pc    <= e1_pc;
          e0_instr <= e1_instr;
          count    <= count - 2'd1;
        end
        2'b11: begin
          if (count == 2'd1) begin
            e0_pc    <= imem_addr;
            e0_instr <= imem_instr;
          end else begin
            e0_pc    <= e1_pc;
            e0_instr <= e1_instr;
            e1_pc    <= imem_addr;
            e1_instr <= imem_instr;
          end
        end
        default: ;
      endcase
    end
  end

  // Registered outputs only. Nothing here depends combinationally on
  // out_ready.
  always_comb begin
    out_valid = (count != 2'd0);
    out_pc    = e0_pc;
    out_instr = e0_instr;
    fault     = (state == FAULT);
    dbg_state = state;
  end

endmodule

// File: tb/tb_fetch_controller.sv
// tb_fetch_controller: directed scenarios plus randomized traffic checked
// against a queue-based reference model of the fetch buffer.
module tb_fetch_controller;

  logic        clk;
  logic        reset;
  logic [31:0] imem_addr;
  logic [31:0] imem_instr;
  logic        halt;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic        fault;
  logic [1:0]  dbg_state;

  int n_cmp = 0;
  int n_bad = 0;

  logic [31:0] mem [0:255];

  // Reference model: the queue holds {pc, instr}, and the head is the oldest.
  logic [63:0] exp_q[$];
  logic [31:0] m_pc;
  int          m_st;   // 0 run, 1 halted, 2 fault

  fetch_controller #(.RESET_PC(32'h0), .IMEM_WORDS(256)) dut (
    .clk(clk), .reset(reset), .imem_addr(imem_addr), .imem_instr(imem_instr),
    .halt(halt), .redirect_valid(redirect_valid), .redirect_target(redirect_target),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
    .out_pc(out_pc), .fault(fault), .dbg_state(dbg_state)
  );

  // Clock generation.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Combinational memory. Addresses outside the memory return a marker word.
  always_comb begin
    if (imem_addr < 32'd1024) imem_instr = mem[imem_addr[9:2]];
    else                      imem_instr = 32'hDEAD_BEEF;
  end

  function automatic logic [97:0] exp_vec();
    logic v;
    v = (exp_q.size() > 0);
    return {v, v ? exp_q[0][63:32] : 32'h0, v ? exp_q[0][31:0] : 32'h0,
            m_pc & 32'hFFFF_FFFC, (m_st == 2)};
  endfunction

  function automatic logic [97:0] obs_vec();
    return {out_valid, out_valid ? out_pc : 32'h0, out_valid ? out_instr : 32'h0,
            imem_addr, fault};
  endfunction

  task automatic model_reset();
    exp_q.delete();
    m_pc = 32'h0;
    m_st = 0;
  endtask

  // Advance the model one clock using the current inputs.
  task automatic model_step();
    int    st0;
    bit    pop;
    bit    want;
    logic [31:0] a;
    st0 = m_st;
    if (redirect_valid) begin
      exp_q.delete();
      m_pc = redirect_target & 32'hFFFF_FFFC;
    end else begin
      pop  = (exp_q.size() > 0) && out_ready;
      want = (st0 == 0) && (exp_q.size() < 2 || pop);
      a    = m_pc;
      if (pop) void'(exp_q.pop_front());
      if (st0 == 0) begin
        if (want && a >= 32'd1024) m_st = 2;
        else if (halt) m_st = 1;
      end else if (st0 == 1 && !halt) begin
        m_st = 0;
      end
      if (want && a < 32'd1024) begin
        exp_q.push_back({a, mem[a >> 2]});
        m_pc = m_pc + 32'd4;
      end
    end
  endtask

  task automatic idle_inputs();
    halt = 1'b0; redirect_valid = 1'b0; redirect_target = 32'h0; out_ready = 1'b0;
  endtask

  // Called 1 time unit after a rising edge. The clock edge falls inside.
  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    idle_inputs();
    reset = 1'b1;
    model_reset();
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1'b1;
    model_reset();
    #1;
    n_cmp++;
    if ({out_valid, fault, out_pc, out_instr, imem_addr} !== {1'b0, 1'b0, 96'h0}) begin
      n_bad++;
      $display("FAIL reset_async: got v=%0b f=%0b pc=%h ins=%h addr=%h want all 0",
               out_valid, fault, out_pc, out_instr, imem_addr);
    end
    @(posedge clk);
    #1;
    n_cmp++;
    if ({out_valid, fault, out_pc, out_instr, imem_addr} !== {1'b0, 1'b0, 96'h0}) begin
      n_bad++;
      $display("FAIL reset_held: got v=%0b f=%0b pc=%h ins=%h addr=%h want all 0",
               out_valid, fault, out_pc, out_instr, imem_addr);
    end
    reset = 1'b0;
    tick();
    n_cmp++;
    if ({out_valid, out_pc, out_instr} !== {1'b1, 32'h0, 32'h20090005}) begin
      n_bad++;
      $display("FAIL first_fetch: got v=%0b pc=%h ins=%h want 1 00000000 20090005",
               out_valid, out_pc, out_instr);
    end
  endtask

  task automatic test_stream();
    apply_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      n_cmp++;
      if (obs_vec() !== exp_vec() || out_pc !== 32'(4 * i) || !out_valid) begin
        n_bad++;
        $display("FAIL stream[%0d]: got %h want %h (pc %h want %h)", i, obs_vec(),
                 exp_vec(), out_pc, 32'(4 * i));
      end
    end
  endtask

  task automatic test_backpressure();
    apply_reset();
    for (int i = 0; i < 5; i++) begin
      tick();
      n_cmp++;
      if (obs_vec() !== exp_vec()) begin
        n_bad++;
        $display("FAIL stall[%0d]: got %h want %h", i, obs_vec(), exp_vec());
      end
    end
    n_cmp++;
    if (imem_addr !== 32'h8 || out_pc !== 32'h0 || !out_valid) begin
      n_bad++;
      $display("FAIL stall_hold: got addr=%h pc=%h want 00000008 00000000", imem_addr, out_pc);
    end
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      n_cmp++;
      if (!out_valid || out_pc !== 32'(4 * i) || out_instr !== mem[i]) begin
        n_bad++;
        $display("FAIL drain[%0d]: got v=%0b pc=%h ins=%h want pc %h ins %h", i,
                 out_valid, out_pc, out_instr, 32'(4 * i), mem[i]);
      end
      tick();
    end
  endtask

  task automatic test_redirect();
    apply_reset();
    tick();
    tick();
    redirect_valid = 1'b1;
    redirect_target = 32'h22;
    tick();
    n_cmp++;
    if (out_valid !== 1'b0 || imem_addr !== 32'h20 || obs_vec() !== exp_vec()) begin
      n_bad++;
      $display("FAIL redirect_flush: got v=%0b addr=%h want 0 00000020", out_valid, imem_addr);
    end
    redirect_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    n_cmp++;
    if (!out_valid || out_pc !== 32'h20 || out_instr !== mem[8]) begin
      n_bad++;
      $display("FAIL redirect_target: got v=%0b pc=%h ins=%h want 1 00000020 %h",
               out_valid, out_pc, out_instr, mem[8]);
    end
  endtask

  task automatic test_halt();
    logic [31:0] frozen;
    apply_reset();
    tick();
    tick();
    halt = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      n_cmp++;
      if (obs_vec() !== exp_vec()) begin
        n_bad++;
        $display("FAIL halt[%0d]: got %h want %h", i, obs_vec(), exp_vec());
      end
    end
    frozen = m_pc;
    n_cmp++;
    if (out_valid !== 1'b0 || imem_addr !== frozen) begin
      n_bad++;
      $display("FAIL halt_frozen: got v=%0b addr=%h want 0 %h", out_valid, imem_addr, frozen);
    end
    halt = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_cmp++;
      if (obs_vec() !== exp_vec() || (i == 1 && (!out_valid || out_pc !== frozen))) begin
        n_bad++;
        $display("FAIL resume[%0d]: got %h want %h (frozen %h)", i, obs_vec(), exp_vec(), frozen);
      end
    end
  endtask

  task automatic test_fault();
    bit seen;
    seen = 1'b0;
    apply_reset();
    redirect_valid = 1'b1;
    redirect_target = 32'h3FC;
    out_ready = 1'b1;
    tick();
    redirect_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (out_valid && out_pc == 32'h3FC && out_instr == mem[255]) seen = 1'b1;
      n_cmp++;
      if (obs_vec() !== exp_vec()) begin
        n_bad++;
        $display("FAIL fault_run[%0d]: got %h want %h", i, obs_vec(), exp_vec());
      end
    end
    n_cmp++;
    if (!seen || fault !== 1'b1 || out_valid !== 1'b0 || dbg_state !== 2'd2) begin
      n_bad++;
      $display("FAIL fault_end: got seen=%0b fault=%0b v=%0b st=%0d want 1 1 0 2",
               seen, fault, out_valid, dbg_state);
    end
    apply_reset();
    n_cmp++;
    if (fault !== 1'b0 || out_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL fault_clear: got fault=%0b v=%0b want 0 0", fault, out_valid);
    end
  endtask

  task automatic test_async_reset();
    for (int sc = 0; sc < 2; sc++) begin
      apply_reset();
      if (sc == 1) begin
        redirect_valid = 1'b1;
        redirect_target = 32'h3F8;
        tick();
        redirect_valid = 1'b0;
      end
      tick();
      tick();
      if (sc == 1) begin
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
      end
      n_cmp++;
      if (obs_vec() !== exp_vec() || !out_valid || fault !== 1'(sc)) begin
        n_bad++;
        $display("FAIL pre_areset[%0d]: got %h want %h", sc, obs_vec(), exp_vec());
      end
      #3;
      reset = 1'b1;
      #1;
      n_cmp++;
      if ({out_valid, fault, out_pc, out_instr, imem_addr} !== {1'b0, 1'b0, 96'h0}) begin
        n_bad++;
        $display("FAIL areset[%0d]: got v=%0b f=%0b pc=%h ins=%h addr=%h want all 0",
                 sc, out_valid, fault, out_pc, out_instr, imem_addr);
      end
      model_reset();
      @(posedge clk);
      #1;
      reset = 1'b0;
    end
  endtask

  task automatic test_random();
    int fault_age;
    fault_age = 0;
    apply_reset();
    for (int i = 0; i < 800; i++) begin
      out_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 19) == 0) halt = ~halt;
      redirect_valid = ($urandom_range(0, 24) == 0);
      if ($urandom_range(0, 3) == 0) redirect_target = 32'h3E0 + $urandom_range(0, 31);
      else                           redirect_target = $urandom_range(0, 1023);
      tick();
      n_cmp++;
      if (obs_vec() !== exp_vec()) begin
        n_bad++;
        $display("FAIL random[%0d]: got %h want %h", i, obs_vec(), exp_vec());
      end
      fault_age = (m_st == 2) ? fault_age + 1 : 0;
      if (fault_age > 4) begin
        apply_reset();
        fault_age = 0;
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = $urandom;
    mem[0] = 32'h20090005;
    mem[1] = 32'h200A000A;
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect();
    test_halt();
    test_fault();
    test_async_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/fetch_controller.md
FETCH_CONTROLLER -- requirements
Module: fetch_controller

Interface
REQ-001 Parameter RESET_PC, default 32'h00000000, SHALL be the byte address fetched first after reset.
REQ-002 Parameter IMEM_WORDS, default 256, SHALL be the instruction memory depth in 32-bit words; the valid byte range is 0 to 4*IMEM_WORDS-1.
REQ-003 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 reset  input  1  SHALL be the asynchronous, active-high reset.
REQ-005 imem_addr  output  32  SHALL be the byte address driven to the combinational instruction memory.
REQ-006 imem_instr  input  32  SHALL be the instruction word returned for imem_addr in the same cycle.
REQ-007 halt  input  1  SHALL be the stop-fetch request (level).
REQ-008 redirect_valid  input  1  SHALL be the branch/jump redirect strobe.
REQ-009 redirect_target  input  32  SHALL be the redirect byte address.
REQ-010 out_valid  output  1  SHALL flag that out_instr/out_pc hold a fetched instruction.
REQ-011 out_ready  input  1  SHALL be the consumer accept signal; a transfer occurs when out_valid and out_ready are both 1.
REQ-012 out_instr  output  32  SHALL be the buffered instruction word.
REQ-013 out_pc  output  32  SHALL be the byte address of out_instr.
REQ-014 fault  output  1  SHALL be a sticky flag set by an out-of-range fetch address.

Function
REQ-015 The block SHALL hold pc (32 b), a 2-entry FIFO of {pc, instr}, a 2-bit count (0..2), and state in {RUN, HALTED, FAULT}.
REQ-016 imem_addr SHALL equal pc with bits [1:0] forced to 0.
REQ-017 A fetch SHALL occur in a cycle when state==RUN, redirect_valid==0, and (count<2 or a pop occurs in the same cycle); on a fetch the entry {pc, imem_instr} is pushed and pc advances by 4 (mod 2^32).
REQ-018 Latency: an instruction fetched in cycle N SHALL be visible on out_* with out_valid=1 in cycle N+1 at the earliest.
REQ-019 out_valid SHALL be 1 exactly when count>0; out_instr/out_pc SHALL show the oldest entry and SHALL stay stable while out_valid=1 and out_ready=0.
REQ-020 A simultaneous push and pop SHALL leave count unchanged and preserve order.
REQ-021 Redirect: with redirect_valid=1 the FIFO SHALL be flushed (count=0), pc SHALL load {redirect_target[31:2],2'b00}, no fetch or pop SHALL occur that cycle, and out_valid SHALL be 0 in the next cycle.
REQ-022 Redirect SHALL take priority over halt, pop and fetch in the same cycle; in HALTED it SHALL update pc but not leave HALTED.
REQ-023 Transitions: RUN->HALTED when halt=1; HALTED->RUN when halt=0; RUN->FAULT when a fetch would occur with imem_addr >= 4*IMEM_WORDS; FAULT is left only by reset.
REQ-024 In HALTED and FAULT no fetch SHALL occur; buffered entries SHALL still drain through out_ready.
REQ-025 On the faulting cycle no entry SHALL be pushed, pc SHALL hold, and fault SHALL be 1 from the next cycle.
REQ-026 pc wrap from 32'hFFFFFFFC to 0 SHALL be a plain increment; it raises fault only through REQ-023.

Reset
REQ-027 Reset asserted at any time, including mid-transfer, SHALL immediately force pc=RESET_PC, count=0, state=RUN, out_valid=0, fault=0, out_instr=0, out_pc=0.
REQ-028 The first fetch SHALL occur in the first clock edge after reset deasserts, from address RESET_PC.

Verification
REQ-029 Reset, out_ready=1 held, memory word0=32'h20090005, word1=32'h200A000A -> out_valid rises one cycle after the first edge; out_pc sequence 0,4,8... with matching instructions, one per cycle.
REQ-030 out_ready=0 for 5 cycles after reset -> count saturates at 2, imem_addr holds 8, out_pc stays 0; out_ready=1 -> out_pc 0,4,8 delivered with no gap or loss.
REQ-031 redirect_valid=1, target=32'h00000022 while count=2 -> next cycle out_valid=0, imem_addr=32'h20; following cycle out_pc=32'h20.
REQ-032 halt=1 with count=2, out_ready=1 -> two entries drain, out_valid=0, imem_addr frozen; halt=0 -> fetch resumes at frozen address.
REQ-033 redirect to 32'h000003FC then run -> instruction at 0x3FC delivered, then fault=1, state FAULT, no further out_valid; reset clears fault.
REQ-034 Reset asserted asynchronously mid-cycle with count=2 -> out_valid and fault drop without waiting for a clock edge; pc=RESET_PC.
